ret_dec_fixup: RTL
==================

Name: ret_dec_fixup

Overview:
- Decode-stage block directly downstream of the return stack; consumes its late return address and produces the return-stack decode update plus a fetch redirect.
- Fires for calls and returns that fetch-time prediction missed, i.e. those the BTB did not flag.
- Scans each decode bundle for the first unpredicted call/return and kills younger slots.
- Issues one fixup per event through a held valid/stall handshake, then discards stale same-fetchID slots until the refetched stream arrives.

Parameters:
- NUM_UOPS, 4, decode slots per cycle.
- CNT_W, 16, width of saturating fixup counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset (0 = reset).
- IN_valid  in  NUM_UOPS  per-slot valid.
- IN_isCall  in  NUM_UOPS  slot decodes as call (jal/jalr, rd=ra).
- IN_isRet  in  NUM_UOPS  slot decodes as return (jalr x0, ra).
- IN_predicted  in  NUM_UOPS  fetch already predicted this slot's call/return.
- IN_compr  in  NUM_UOPS  slot is a 16-bit instruction.
- IN_pc  in  NUM_UOPS*31  halfword PC of slot's first halfword.
- IN_fetchID  in  NUM_UOPS*FetchID_t  fetch packet ID.
- IN_offs  in  NUM_UOPS*FetchOff_t  offset of slot's last halfword.
- IN_retIdx  in  NUM_UOPS*RetStackIdx_t  return-stack index sampled at fetch.
- IN_lateRetAddr  in  31  return stack OUT_lateRetAddr.
- IN_stall  in  1  return stack OUT_stall; fixup must hold.
- IN_flush  in  1  backend mispredict; cancels everything.
- OUT_kill  out  NUM_UOPS  combinational squash mask for slots younger than the trigger.
- OUT_ready  out  1  decode may advance.
- OUT_returnUpd  out  ReturnDecUpdate  {valid, idx, addr} to return stack.
- OUT_mispr  out  FetchBranchProv  redirect {taken, fetchID, fetchOffs, isFetchBranch, dst}.
- OUT_fixCnt  out  CNT_W  saturating count of issued fixups.

Behaviour:
- Reset: all outputs 0, valid/taken 0, OUT_ready=1, state IDLE, OUT_fixCnt=0.
- Trigger: lowest slot i with IN_valid[i] & (isCall|isRet) & !predicted; slot i is kept, slots >i are killed.
- isCall and isRet both set on one slot: treated as call.
- States:
  - IDLE, trigger present: register fixup, go ISSUE next cycle (latency 1).
  - ISSUE: OUT_mispr.taken=1 and, for a call, OUT_returnUpd.valid=1; held stable while IN_stall=1.
    - Call: idx = retIdx+1, addr = pc + (compr?0:1) (last halfword), dst = call target is not known here, so dst = pc+(compr?1:2) (fall-through).
    - Return: returnUpd.valid=0, dst = IN_lateRetAddr, sampled on the ISSUE cycle.
    - mispr.fetchID and fetchOffs are the trigger's; isFetchBranch=1.
    - First cycle with IN_stall=0: deassert, OUT_fixCnt++ (saturate at all-ones), go DRAIN with staleID=trigger fetchID.
  - DRAIN: all valid slots whose fetchID==staleID are killed.
    - First valid slot with a different fetchID returns to IDLE and is evaluated that same cycle.
- OUT_ready=0 during ISSUE; 1 otherwise.
- IN_flush: highest priority in any state; go IDLE, drop pending fixup, outputs invalid next cycle, no count increment, kill mask 0 that cycle.
- Reset asserted mid-ISSUE: outputs clear immediately (async).
- Trigger in slot NUM_UOPS-1: kill mask all zero.
- All FetchID comparisons are equality only; wrap-around is irrelevant.

Decomposition:
- Shared package: ReturnDecUpdate, FetchBranchProv, FetchID_t, FetchOff_t, RetStackIdx_t (existing types); add enum FixupState_t {FX_IDLE, FX_ISSUE, FX_DRAIN}.
- One sub-module: ret_dec_prio_sel (priority-select first trigger index plus younger-kill mask).

Test Plan:
- Unpredicted return in slot 2, lateRetAddr=0x100 -> kill=4'b1000; next cycle mispr.taken=1, dst=0x100, returnUpd.valid=0; fixCnt=1.
- Unpredicted 32-bit call at pc=0x40, retIdx=3, slot 0 -> returnUpd {1, idx=4, addr=0x41}, dst=0x42, kill=4'b1110.
- IN_stall=1 for 3 cycles during ISSUE -> outputs bit-identical for all 3 cycles, OUT_ready=0, count increments once after release.
- After fixup on fetchID 5, bundle {5,5,6,6} with return predicted=0 in slot 0 -> slots 0,1 killed; slot 2 evaluated normally.
- IN_flush in ISSUE -> next cycle all outputs invalid, fixCnt unchanged, state IDLE.
- Predicted call plus unpredicted call in the same bundle -> only the unpredicted one triggers; fixCnt saturates at 0xFFFF after 65536+ fixups.

Source files
------------

// File: rtl/ret_dec_fixup_pkg.sv
// Shared types for the decode-stage return-stack fixup: fetch/return-stack
// field types, the bus payload structs, and the fixup FSM state.
package ret_dec_fixup_pkg;

    localparam int FETCH_ID_W  = 5;
    localparam int FETCH_OFF_W = 3;
    localparam int RET_IDX_W   = 4;
    localparam int PC_W        = 31;

    typedef logic [FETCH_ID_W-1:0]  FetchID_t;
    typedef logic [FETCH_OFF_W-1:0] FetchOff_t;
    typedef logic [RET_IDX_W-1:0]   RetStackIdx_t;

    typedef struct packed {
        logic             valid;
        RetStackIdx_t     idx;
        logic [PC_W-1:0]  addr;
    } ReturnDecUpdate;

    typedef struct packed {
        logic             taken;
        FetchID_t         fetchID;
        FetchOff_t        fetchOffs;
        logic             isFetchBranch;
        logic [PC_W-1:0]  dst;
    } FetchBranchProv;

    typedef enum logic [1:0] {
        FX_IDLE,
        FX_ISSUE,
        FX_DRAIN
    } FixupState_t;

    // Everything about the trigger slot is resolved at capture time so the
    // ISSUE state only has to drive registered values.
    typedef struct packed {
        logic             is_call;
        FetchID_t         fetch_id;
        FetchOff_t        offs;
        RetStackIdx_t     ret_idx;
        logic [PC_W-1:0]  ret_addr;
        logic [PC_W-1:0]  dst;
    } FixupReq_t;

endpackage

// File: rtl/ret_dec_fixup_if.sv
// Decode-bundle / return-stack bus seen by ret_dec_fixup; the block itself
// sits on the slave side.
interface ret_dec_fixup_if
    import ret_dec_fixup_pkg::*;
#(
    parameter int NUM_UOPS = 4
);

    logic [NUM_UOPS-1:0]            IN_valid;
    logic [NUM_UOPS-1:0]            IN_isCall;
    logic [NUM_UOPS-1:0]            IN_isRet;
    logic [NUM_UOPS-1:0]            IN_predicted;
    logic [NUM_UOPS-1:0]            IN_compr;
    logic [NUM_UOPS-1:0][PC_W-1:0]  IN_pc;
    FetchID_t [NUM_UOPS-1:0]        IN_fetchID;
    FetchOff_t [NUM_UOPS-1:0]       IN_offs;
    RetStackIdx_t [NUM_UOPS-1:0]    IN_retIdx;
    logic [PC_W-1:0]                IN_lateRetAddr;
    logic                           IN_stall;
    logic                           IN_flush;

    logic [NUM_UOPS-1:0]            OUT_kill;
    logic                           OUT_ready;
    ReturnDecUpdate                 OUT_returnUpd;
    FetchBranchProv                 OUT_mispr;

    modport master (
        output IN_valid, IN_isCall, IN_isRet, IN_predicted, IN_compr,
        output IN_pc, IN_fetchID, IN_offs, IN_retIdx,
        output IN_lateRetAddr, IN_stall, IN_flush,
        input  OUT_kill, OUT_ready, OUT_returnUpd, OUT_mispr
    );

    modport slave (
        input  IN_valid, IN_isCall, IN_isRet, IN_predicted, IN_compr,
        input  IN_pc, IN_fetchID, IN_offs, IN_retIdx,
        input  IN_lateRetAddr, IN_stall, IN_flush,
        output OUT_kill, OUT_ready, OUT_returnUpd, OUT_mispr
    );

endinterface

// File: rtl/ret_dec_fixup_prio_sel.sv
// Priority select: index of the lowest set candidate bit plus a mask of every
// slot above it (younger in program order).
module ret_dec_prio_sel #(
    parameter int  N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     cand,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     younger
);

    always_comb begin
        found   = 1'b0;
        idx     = '0;
        younger = '0;
        for (int i = 0; i < N; i++) begin
            if (found) begin
                younger[i] = 1'b1;
            end else if (cand[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ret_dec_fixup.sv
// Decode-time fixup for calls/returns the BTB missed: picks the first one in
// the bundle, redirects fetch / updates the return stack, then drains stale slots.
module ret_dec_fixup
    import ret_dec_fixup_pkg::*;
#(
    parameter int  NUM_UOPS = 4,
    parameter int  CNT_W    = 16,
    localparam int IDX_W    = (NUM_UOPS > 1) ? $clog2(NUM_UOPS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    ret_dec_fixup_if.slave      bus,
    output logic [CNT_W-1:0]    OUT_fixCnt
);

    FixupState_t          state_q, state_d;
    FixupReq_t            fix_q, fix_d, fix_new;
    FetchID_t             stale_id_q, stale_id_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [NUM_UOPS-1:0]  stale;
    logic [NUM_UOPS-1:0]  fresh;
    logic [NUM_UOPS-1:0]  cand;
    logic [NUM_UOPS-1:0]  younger;
    logic                 trig_found;
    logic [IDX_W-1:0]     trig_idx;

    // Slots of the already-fixed fetch packet are never triggers while draining.
    always_comb begin
        stale = '0;
        cand  = '0;
        for (int i = 0; i < NUM_UOPS; i++) begin
            stale[i] = (state_q == FX_DRAIN) && bus.IN_valid[i]
                       && (bus.IN_fetchID[i] == stale_id_q);
            cand[i]  = (state_q != FX_ISSUE) && bus.IN_valid[i] && !stale[i]
                       && (bus.IN_isCall[i] || bus.IN_isRet[i])
                       && !bus.IN_predicted[i];
        end
        fresh = bus.IN_valid & ~stale;
    end

    ret_dec_prio_sel #(.N(NUM_UOPS)) u_prio_sel (
        .cand    (cand),
        .found   (trig_found),
        .idx     (trig_idx),
        .younger (younger)
    );

    always_comb begin
        fix_new          = '0;
        fix_new.is_call  = bus.IN_isCall[trig_idx];
        fix_new.fetch_id = bus.IN_fetchID[trig_idx];
        fix_new.offs     = bus.IN_offs[trig_idx];
        fix_new.ret_idx  = bus.IN_retIdx[trig_idx] + RetStackIdx_t'(1);
        fix_new.ret_addr = bus.IN_pc[trig_idx] + (bus.IN_compr[trig_idx] ? 31'd0 : 31'd1);
        fix_new.dst      = bus.IN_pc[trig_idx] + (bus.IN_compr[trig_idx] ? 31'd1 : 31'd2);
    end

    always_comb begin
        state_d    = state_q;
        fix_d      = fix_q;
        stale_id_d = stale_id_q;
        cnt_d      = cnt_q;
        if (bus.IN_flush) begin
            state_d = FX_IDLE;
        end else begin
            unique case (state_q)
                FX_IDLE: begin
                    if (trig_found) begin
                        fix_d   = fix_new;
                        state_d = FX_ISSUE;
                    end
                end
                FX_ISSUE: begin
                    if (!bus.IN_stall) begin
                        cnt_d      = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                        stale_id_d = fix_q.fetch_id;
                        state_d    = FX_DRAIN;
                    end
                end
                FX_DRAIN: begin
                    if (trig_found) begin
                        fix_d   = fix_new;
                        state_d = FX_ISSUE;
                    end else if (|fresh) begin
                        state_d = FX_IDLE;
                    end
                end
                default: state_d = FX_IDLE;
            endcase
        end
    end

    // Outputs derive from state_q so an async reset clears them immediately.
    always_comb begin
        bus.OUT_returnUpd = '0;
        bus.OUT_mispr     = '0;
        bus.OUT_kill      = '0;
        bus.OUT_ready     = (state_q != FX_ISSUE);
        if (state_q == FX_ISSUE) begin
            bus.OUT_mispr.taken         = 1'b1;
            bus.OUT_mispr.fetchID       = fix_q.fetch_id;
            bus.OUT_mispr.fetchOffs     = fix_q.offs;
            bus.OUT_mispr.isFetchBranch = 1'b1;
            if (fix_q.is_call) begin
                bus.OUT_returnUpd.valid = 1'b1;
                bus.OUT_returnUpd.idx   = fix_q.ret_idx;
                bus.OUT_returnUpd.addr  = fix_q.ret_addr;
                bus.OUT_mispr.dst       = fix_q.dst;
            end else begin
                bus.OUT_mispr.dst       = bus.IN_lateRetAddr;
            end
        end else if (!bus.IN_flush) begin
            bus.OUT_kill = (trig_found ? younger : '0) | stale;
        end
    end

    assign OUT_fixCnt = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FX_IDLE;
            fix_q      <= '0;
            stale_id_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            fix_q      <= fix_d;
            stale_id_q <= stale_id_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
